// File: rtl/controle_autenticacao_if.sv
// controle_autenticacao_if: code switches, enter request and result display/status bundle
interface controle_autenticacao_if;
    logic [2:0] sw;
    logic       enter;
    logic [6:0] P;
    logic       granted;
    logic       denied;
    logic       locked;
    logic [1:0] tries;
    modport master (output sw, enter, input P, granted, denied, locked, tries);
    modport slave  (input sw, enter, output P, granted, denied, locked, tries);
endinterface

// File: rtl/controle_autenticacao.sv
// controle_autenticacao: access-code check sequencer with failed-attempt lockout and 7-seg result
module controle_autenticacao #(
    parameter logic [2:0] CODE        = 3'b101,
    parameter int         MAX_TRIES   = 3,
    parameter int         SHOW_CYCLES = 8,
    parameter int         LOCK_CYCLES = 32,
    parameter int         TIMER_W     = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    controle_autenticacao_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, GRANTED, DENIED, LOCKED} state_t;
    localparam logic [1:0]         MAX_T  = 2'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] SHOW_T = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_T = TIMER_W'(LOCK_CYCLES - 1);
    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               enter_q;
    logic [2:0]         code_q;
    logic [1:0]         tries;
    logic [9:0]         out_q;
    wire                press = bus.enter & ~enter_q;
    // {P, granted, denied, locked} for the state being entered
    function automatic logic [9:0] outs(state_t s);
        return s == GRANTED ? {7'b1110111, 3'b100} :
               s == DENIED  ? {7'b1001111, 3'b010} :
               s == LOCKED  ? {7'b0001110, 3'b001} : {7'b0000001, 3'b000};
    endfunction
    assign bus.P       = out_q[9:3];
    assign bus.granted = out_q[2];
    assign bus.denied  = out_q[1];
    assign bus.locked  = out_q[0];
    assign bus.tries   = tries;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            enter_q <= 1'b0;
            code_q  <= '0;
            tries   <= '0;
            out_q   <= outs(IDLE);
        end else begin
            enter_q <= bus.enter;
            case (state)
                IDLE: if (press) begin
                    code_q <= bus.sw;
                    state  <= CHECK;
                end
                CHECK: if (code_q == CODE) begin
                    state <= GRANTED;
                    tries <= '0;
                    timer <= SHOW_T;
                    out_q <= outs(GRANTED);
                end else if (tries + 2'd1 == MAX_T) begin
                    state <= LOCKED;
                    tries <= tries + 2'd1;
                    timer <= LOCK_T;
                    out_q <= outs(LOCKED);
                end else begin
                    state <= DENIED;
                    tries <= tries + 2'd1;
                    timer <= SHOW_T;
                    out_q <= outs(DENIED);
                end
                GRANTED, DENIED: if (timer == '0) begin
                    state <= IDLE;
                    out_q <= outs(IDLE);
                end else timer <= timer - 1'b1;
                LOCKED: if (timer == '0) begin
                    state <= IDLE;
                    tries <= '0;
                    out_q <= outs(IDLE);
                end else timer <= timer - 1'b1;
                default: begin
                    state <= IDLE;
                    out_q <= outs(IDLE);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controle_autenticacao.sv
// tb_controle_autenticacao: directed and random attempts checked against an attempt-timeline model
module tb_controle_autenticacao;
    localparam int SHOW = 8;
    localparam int LOCK = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    controle_autenticacao_if bus();
    controle_autenticacao dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0, failures = 0;
    // model: edge count, last accepted attempt (edge, kind 1=G 2=D 3=L, length), tries
    int j = 0, a_edge = -1000, a_kind = 0, a_len = 0, a_tries = 0, free_at = 0, m_tries = 0;
    logic prev = 1'b0;
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [9:0] exp_out(int k);
        return k == 1 ? {7'b1110111, 3'b100} : k == 2 ? {7'b1001111, 3'b010} :
               k == 3 ? {7'b0001110, 3'b001} : {7'b0000001, 3'b000};
    endfunction
    task automatic check_all(string tag);
        int k;
        logic [9:0] e;
        k = (j >= a_edge + 1 && j <= a_edge + a_len) ? a_kind : 0;
        e = exp_out(k);
        check({tag, ".P"}, 32'(bus.P), 32'(e[9:3]));
        check({tag, ".granted"}, 32'(bus.granted), 32'(e[2]));
        check({tag, ".denied"}, 32'(bus.denied), 32'(e[1]));
        check({tag, ".locked"}, 32'(bus.locked), 32'(e[0]));
        check({tag, ".tries"}, 32'(bus.tries), 32'(m_tries));
    endtask
    task automatic model_edge(logic e, logic [2:0] s);
        if (j == a_edge + 1) m_tries = a_tries;
        if (a_kind == 3 && j == a_edge + a_len + 1) m_tries = 0;
        if (e && !prev && j >= free_at) begin
            a_edge  = j;
            a_kind  = (s == 3'b101) ? 1 : (m_tries + 1 == 3 ? 3 : 2);
            a_len   = (a_kind == 3) ? LOCK : SHOW;
            a_tries = (a_kind == 1) ? 0 : m_tries + 1;
            free_at = j + a_len + 2;
        end
        prev = e;
    endtask
    task automatic step(logic e, logic [2:0] s, string tag);
        bus.enter = e;
        bus.sw = s;
        @(posedge clk);
        j++;
        model_edge(e, s);
        #1;
        check_all(tag);
    endtask
    task automatic run(int n, logic e, logic [2:0] s, string tag);
        repeat (n) step(e, s, tag);
    endtask
    task automatic areset(string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        a_edge = -1000; a_kind = 0; a_len = 0; m_tries = 0; free_at = 0; prev = 1'b0;
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask
    initial begin
        bus.enter = 1'b0;
        bus.sw = 3'b000;
        #12;
        check_all("reset");
        rst_n = 1'b1;
        step(1'b1, 3'b101, "grant");
        run(12, 1'b0, 3'b010, "grant");
        step(1'b1, 3'b011, "wrong1");
        run(11, 1'b0, 3'b011, "wrong1");
        step(1'b1, 3'b011, "wrong2");
        run(11, 1'b0, 3'b000, "wrong2");
        step(1'b1, 3'b101, "recover");
        run(11, 1'b0, 3'b101, "recover");
        repeat (3) begin
            step(1'b1, 3'b110, "lock_in");
            run(11, 1'b0, 3'b110, "lock_in");
        end
        repeat (18) begin
            step(1'b1, 3'b101, "lock_press");
            step(1'b0, 3'b101, "lock_press");
        end
        run(12, 1'b0, 3'b000, "lock_exit");
        run(40, 1'b1, 3'b011, "held");
        run(12, 1'b0, 3'b011, "held");
        repeat (3) begin
            step(1'b1, 3'b011, "lock2");
            run(11, 1'b0, 3'b011, "lock2");
        end
        areset("rst_lock");
        step(1'b1, 3'b101, "post_rst");
        run(10, 1'b0, 3'b101, "post_rst");
        repeat (400) begin
            logic [2:0] s;
            s = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) areset("rand_rst");
            step($urandom_range(0, 2) == 0, s, "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
